// File: rtl/mem_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_seq
//  Description : Walks an inclusive address range of a memory, reads each
//                word, loads it into a serial shifter and waits for the
//                shifter to finish before moving to the next address.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_seq #(
  parameter int          MEM_LAT    = 1,
  parameter logic [15:0] TX_TIMEOUT = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] START_ADDR,
  input  logic [7:0] END_ADDR,
  input  logic       TX_DONE,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_VALID,
  output logic       MEM_RW,
  output logic       PARALLEL_LOAD,
  output logic       START_TX,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [8:0] WORD_COUNT
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_read   = 3'd1;
  localparam logic [2:0] c_st_wait   = 3'd2;
  localparam logic [2:0] c_st_load   = 3'd3;
  localparam logic [2:0] c_st_send   = 3'd4;
  localparam logic [2:0] c_st_next   = 3'd5;
  localparam logic [2:0] c_st_finish = 3'd6;

  // Counters run down/up to these terminal values.
  localparam logic [3:0]  c_wait_last = 4'(MEM_LAT - 1);
  localparam logic [15:0] c_tx_last   = TX_TIMEOUT - 16'd1;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [7:0]  r_cur_addr;
  logic [7:0]  r_end_addr;
  logic [7:0]  w_next_addr;
  logic [3:0]  r_wait_cnt;
  logic [15:0] r_tx_cnt;
  logic        w_abort;
  logic        w_tx_timeout;
  logic        w_start;

  logic [7:0]  r_mem_addr;
  logic        r_mem_valid;
  logic        r_pload;
  logic        r_start_tx;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [8:0]  r_word_count;

  // ABORT only matters while a dump is actually running.
  assign w_abort      = ABORT && (r_state != c_st_idle) && (r_state != c_st_finish);
  assign w_start      = START && (r_state == c_st_idle);
  assign w_tx_timeout = (r_state == c_st_send) && !TX_DONE && !w_abort &&
                        (r_tx_cnt == c_tx_last);

  // Next-state and next-address selection; ABORT overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_cur_addr;
    case (r_state)
      c_st_idle: begin
        if (START) begin
          w_next_addr  = START_ADDR;
          w_next_state = (START_ADDR <= END_ADDR) ? c_st_read : c_st_finish;
        end
      end
      c_st_read: w_next_state = c_st_wait;
      c_st_wait: begin
        if (r_wait_cnt == 4'd0) w_next_state = c_st_load;
      end
      c_st_load: w_next_state = c_st_send;
      c_st_send: begin
        if (TX_DONE)                     w_next_state = c_st_next;
        else if (r_tx_cnt == c_tx_last)  w_next_state = c_st_finish;
      end
      c_st_next: begin
        // Compare before incrementing so a range ending at 255 never wraps.
        if (r_cur_addr == r_end_addr) begin
          w_next_state = c_st_finish;
        end else begin
          w_next_addr  = r_cur_addr + 8'd1;
          w_next_state = c_st_read;
        end
      end
      c_st_finish: w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
    if (w_abort) w_next_state = c_st_finish;
  end

  // State, address and per-state cycle counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= c_st_idle;
      r_cur_addr <= 8'd0;
      r_end_addr <= 8'd0;
      r_wait_cnt <= 4'd0;
      r_tx_cnt   <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_cur_addr <= w_next_addr;
      if (w_start) r_end_addr <= END_ADDR;
      // Counters idle at their start value and only move inside their state.
      if (r_state != c_st_wait) r_wait_cnt <= c_wait_last;
      else                      r_wait_cnt <= r_wait_cnt - 4'd1;
      if (r_state != c_st_send) r_tx_cnt <= 16'd0;
      else                      r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  // Registered strobes decoded from the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mem_addr  <= 8'd0;
      r_mem_valid <= 1'b0;
      r_pload     <= 1'b0;
      r_start_tx  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_next_state == c_st_read) r_mem_addr <= w_next_addr;
      r_mem_valid <= (w_next_state == c_st_read);
      r_pload     <= (w_next_state == c_st_load);
      r_start_tx  <= (w_next_state == c_st_send);
      r_busy      <= (w_next_state != c_st_idle) && (w_next_state != c_st_finish);
      r_done      <= (w_next_state == c_st_finish);
    end
  end

  // Error flag and completed-word counter for the current/last dump.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err        <= 1'b0;
      r_word_count <= 9'd0;
    end else begin
      if (w_start) begin
        r_err        <= (START_ADDR > END_ADDR);
        r_word_count <= 9'd0;
      end else begin
        if (w_tx_timeout) r_err <= 1'b1;
        if ((r_state == c_st_next) && !w_abort) r_word_count <= r_word_count + 9'd1;
      end
    end
  end

  assign MEM_ADDR      = r_mem_addr;
  assign MEM_VALID     = r_mem_valid;
  assign MEM_RW        = 1'b0;
  assign PARALLEL_LOAD = r_pload;
  assign START_TX      = r_start_tx;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign ERR           = r_err;
  assign WORD_COUNT    = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dump_seq
//  Description : Scoreboard bench for mem_dump_seq. The driver issues dumps
//                and pushes the expected reads, shifter-enable run lengths
//                and end-of-dump results; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_seq;

  localparam int          MEM_LAT    = 2;
  localparam logic [15:0] TX_TIMEOUT = 16'd20;
  localparam int          T_TO       = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic       ABORT;
  logic [7:0] START_ADDR;
  logic [7:0] END_ADDR;
  logic       TX_DONE;
  logic [7:0] MEM_ADDR;
  logic       MEM_VALID;
  logic       MEM_RW;
  logic       PARALLEL_LOAD;
  logic       START_TX;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [8:0] WORD_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_addr[$];
  int exp_run[$];
  int exp_wc[$];
  int exp_err[$];

  mem_dump_seq #(
    .MEM_LAT    (MEM_LAT),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .ABORT         (ABORT),
    .START_ADDR    (START_ADDR),
    .END_ADDR      (END_ADDR),
    .TX_DONE       (TX_DONE),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_VALID     (MEM_VALID),
    .MEM_RW        (MEM_RW),
    .PARALLEL_LOAD (PARALLEL_LOAD),
    .START_TX      (START_TX),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR           (ERR),
    .WORD_COUNT    (WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},   MEM_ADDR, 0);
    check({tag, "_mem_valid"},  MEM_VALID, 0);
    check({tag, "_mem_rw"},     MEM_RW, 0);
    check({tag, "_pload"},      PARALLEL_LOAD, 0);
    check({tag, "_start_tx"},   START_TX, 0);
    check({tag, "_busy"},       BUSY, 0);
    check({tag, "_done"},       DONE, 0);
    check({tag, "_err"},        ERR, 0);
    check({tag, "_word_count"}, WORD_COUNT, 0);
  endtask

  // mode 0: normal, 1: ABORT with TX_DONE on word k, 2: no TX_DONE on word k,
  // 3: asynchronous reset during SEND of word k. poke = START while busy.
  task automatic run_dump(input int s, input int e, input int mode, input int k, input bit poke);
    int n;
    int nread;
    int cnt;
    int d[$];
    n     = (s <= e) ? (e - s + 1) : 0;
    nread = (mode == 0) ? n : k;
    for (int i = 0; i < nread; i++) d.push_back($urandom_range(0, 6));
    for (int i = 0; i < nread; i++) begin
      exp_addr.push_back(s + i);
      if (mode == 2 && i == k - 1)       exp_run.push_back(T_TO);
      else if (!(mode == 3 && i == k - 1)) exp_run.push_back(d[i] + 1);
    end
    if (mode != 3) begin
      exp_wc.push_back((mode == 0) ? n : k - 1);
      exp_err.push_back((n == 0 || mode == 2) ? 1 : 0);
    end

    @(negedge CLK);
    START_ADDR = s[7:0];
    END_ADDR   = e[7:0];
    START      = 1'b1;
    @(negedge CLK);
    START      = 1'b0;
    START_ADDR = 8'($urandom);
    END_ADDR   = 8'($urandom);

    for (int i = 0; i < nread; i++) begin
      cnt = 0;
      while (!START_TX && cnt < 100) begin
        @(negedge CLK);
        cnt++;
      end
      check("send_seen", START_TX, 1);
      if (!START_TX) return;
      if (mode == 2 && i == k - 1) break;
      repeat (d[i]) @(negedge CLK);
      if (mode == 3 && i == k - 1) begin
        #3 RESET = 1'b1;
        #1 check_all_zero("midsend_rst");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        return;
      end
      TX_DONE = 1'b1;
      ABORT   = (mode == 1 && i == k - 1);
      START   = poke;
      if (poke) begin
        START_ADDR = 8'($urandom);
        END_ADDR   = 8'($urandom);
      end
      @(negedge CLK);
      TX_DONE = 1'b0;
      ABORT   = 1'b0;
      START   = 1'b0;
    end

    cnt = 0;
    while (!DONE && cnt < T_TO + 100) begin
      @(negedge CLK);
      cnt++;
    end
    check("done_seen", DONE, 1);
    if (mode == 0 && n > 0) check("last_mem_addr", MEM_ADDR, e);
    repeat (2) @(negedge CLK);
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  initial begin : monitor
    int  since_valid;
    int  tx_run;
    bit  prev_done;
    since_valid = 0;
    tx_run      = 0;
    prev_done   = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        tx_run    = 0;
        prev_done = 1'b0;
      end else begin
        since_valid++;
        if (prev_done) check("done_one_cycle", DONE, 0);
        prev_done = DONE;
        if (MEM_VALID) begin
          since_valid = 0;
          check("read_busy", BUSY, 1);
          check("read_rw", MEM_RW, 0);
          if (exp_addr.size() == 0) check("unexpected_read", MEM_VALID, 0);
          else                      check("read_addr", MEM_ADDR, exp_addr.pop_front());
        end
        if (PARALLEL_LOAD) check("load_latency", since_valid, MEM_LAT + 1);
        if (START_TX) begin
          tx_run++;
        end else if (tx_run > 0) begin
          if (exp_run.size() == 0) check("unexpected_tx_run", tx_run, 0);
          else                     check("tx_run_len", tx_run, exp_run.pop_front());
          tx_run = 0;
        end
        if (DONE) begin
          check("done_busy", BUSY, 0);
          if (exp_wc.size() == 0) begin
            check("unexpected_done", DONE, 0);
          end else begin
            check("word_count", WORD_COUNT, exp_wc.pop_front());
            check("err", ERR, exp_err.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int s;
    int e;
    int n;
    int mode;
    RESET      = 1'b1;
    START      = 1'b0;
    ABORT      = 1'b0;
    TX_DONE    = 1'b0;
    START_ADDR = 8'd0;
    END_ADDR   = 8'd0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // ABORT while idle must not start or finish anything.
    ABORT = 1'b1;
    repeat (2) @(negedge CLK);
    ABORT = 1'b0;

    run_dump(3, 5, 0, 0, 1'b0);
    run_dump(7, 7, 0, 0, 1'b0);
    run_dump(8, 7, 0, 0, 1'b0);
    run_dump(250, 255, 0, 0, 1'b0);
    run_dump(0, 9, 1, 2, 1'b1);
    run_dump(2, 6, 2, 3, 1'b0);
    run_dump(10, 14, 3, 2, 1'b0);
    run_dump(20, 22, 0, 0, 1'b1);
    run_dump(0, 255, 0, 0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      s = $urandom_range(0, 255);
      e = s + $urandom_range(0, 7);
      if (e > 255) e = 255;
      if (s > 0 && $urandom_range(0, 9) == 0) begin
        run_dump(s, s - 1, 0, 0, 1'b0);
      end else begin
        n    = e - s + 1;
        mode = $urandom_range(0, 2);
        run_dump(s, e, mode, $urandom_range(1, n), 1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge CLK);
    check("pending_reads", exp_addr.size(), 0);
    check("pending_tx_runs", exp_run.size(), 0);
    check("pending_dones", exp_wc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
